fmul_pipe_hs: RTL and testbench

//  Parametrised successor of the fixed 4/4 FloPoCo-format multiplier.
//  - Computes R = X*Y for any exponent/fraction width.
//  - Adds a valid/ready elastic pipeline and a sideband tag.
//  - Sits between HLS-scheduled producers/consumers in generated datapaths.
//  - Operand/result format: {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
//  - exc encoding: 00 zero, 01 normal, 10 inf, 11 NaN.
//  - Exponent bias is 2^(WE-1)-1.

---
 rtl/fmul_pipe_hs.sv | 163 ++++++++++++++++
 tb/tb_fmul_pipe_hs.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe_hs.sv
// Three-stage elastic floating-point multiplier (FloPoCo-style operands) with a sideband tag.
// Defining FMUL_FLAGS_EN adds sticky exception flags with a clear input.
module fmul_pipe_hs #(
   parameter int WE    = 4,
   parameter int WF    = 4,
   parameter int TAG_W = 8,
   parameter int ID    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WE+WF+2:0]     X,
   input  logic [WE+WF+2:0]     Y,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WE+WF+2:0]     R,
   output logic [TAG_W-1:0]     out_tag
`ifdef FMUL_FLAGS_EN
   ,
   input  logic                 flag_clr,
   output logic [3:0]           flags
`endif
);

   localparam int W      = WE + WF + 3;
   localparam int PW     = 2 * WF + 2;
   localparam int TW     = TAG_W + 0 * ID;
   localparam int BIAS_I = (1 << (WE - 1)) - 1;
   localparam logic [WE+1:0] BIAS = BIAS_I[WE+1:0];

   logic adv;

   // Every stage advances together; reset forces acceptance so upstream never waits on it.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv | ~rst_n;

   logic [1:0]    xe, ye, exc_c;
   logic          sign_c;
   logic [WE+1:0] expsum_c;
   logic [PW-1:0] prod_c;

   always_comb begin
      xe       = X[W-1:W-2];
      ye       = Y[W-1:W-2];
      sign_c   = X[WE+WF] ^ Y[WE+WF];
      exc_c    = 2'b01;
      if (xe == 2'b11 || ye == 2'b11)
         exc_c = 2'b11;
      else if ((xe == 2'b00 && ye == 2'b10) || (xe == 2'b10 && ye == 2'b00))
         exc_c = 2'b11;
      else if (xe == 2'b10 || ye == 2'b10)
         exc_c = 2'b10;
      else if (xe == 2'b00 || ye == 2'b00)
         exc_c = 2'b00;
      expsum_c = {2'b00, X[WE+WF-1:WF]} + {2'b00, Y[WE+WF-1:WF]} - BIAS;
      prod_c   = {{(WF+1){1'b0}}, 1'b1, X[WF-1:0]} * {{(WF+1){1'b0}}, 1'b1, Y[WF-1:0]};
   end

   logic          s1_valid, s1_sign;
   logic [TW-1:0] s1_tag;
   logic [1:0]    s1_exc;
   logic [WE+1:0] s1_expsum;
   logic [PW-1:0] s1_prod;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_tag    <= '0;
         s1_sign   <= 1'b0;
         s1_exc    <= 2'b00;
         s1_expsum <= '0;
         s1_prod   <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s1_tag    <= in_tag;
         s1_sign   <= sign_c;
         s1_exc    <= exc_c;
         s1_expsum <= expsum_c;
         s1_prod   <= prod_c;
      end
   end

   logic          norm, guard, sticky, round_up;
   logic [WF-1:0] frac_pre;
   logic [WF:0]   frac_sum;
   logic [WE+1:0] exp_r;
   logic [W-1:0]  res_c;

   // A rounding carry out of the fraction leaves it all-zero and bumps the exponent.
   always_comb begin
      norm     = s1_prod[PW-1];
      frac_pre = norm ? s1_prod[PW-2 -: WF] : s1_prod[PW-3 -: WF];
      guard    = norm ? s1_prod[WF] : s1_prod[WF-1];
      sticky   = norm ? |s1_prod[WF-1:0] : |s1_prod[WF-2:0];
      round_up = guard & (sticky | frac_pre[0]);
      frac_sum = {1'b0, frac_pre} + {{WF{1'b0}}, round_up};
      exp_r    = s1_expsum + {{(WE+1){1'b0}}, norm} + {{(WE+1){1'b0}}, frac_sum[WF]};
      res_c    = {s1_exc, s1_sign, {(WE+WF){1'b0}}};
      if (s1_exc == 2'b01) begin
         case (exp_r[WE+1:WE])
            2'b00:   res_c = {2'b01, s1_sign, exp_r[WE-1:0], frac_sum[WF-1:0]};
            2'b01:   res_c = {2'b10, s1_sign, {(WE+WF){1'b0}}};
            default: res_c = {2'b00, s1_sign, {(WE+WF){1'b0}}};
         endcase
      end
   end

`ifdef FMUL_FLAGS_EN
   logic [3:0] ev_c, s2_ev, out_ev;
   logic       is_norm;

   assign is_norm = (s1_exc == 2'b01);
   assign ev_c    = {s1_exc == 2'b11,
                     is_norm & (exp_r[WE+1:WE] == 2'b01),
                     is_norm & exp_r[WE+1],
                     is_norm & (guard | sticky | (exp_r[WE+1:WE] != 2'b00))};
`endif

   logic          s2_valid;
   logic [TW-1:0] s2_tag;
   logic [W-1:0]  s2_res;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_tag    <= '0;
         s2_res    <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
         R         <= '0;
      end else if (adv) begin
         s2_valid  <= s1_valid;
         s2_tag    <= s1_tag;
         s2_res    <= res_c;
         out_valid <= s2_valid;
         out_tag   <= s2_tag;
         R         <= s2_res;
      end
   end

`ifdef FMUL_FLAGS_EN
   // Events ride with their result and are only folded in when that result handshakes out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_ev  <= 4'b0000;
         out_ev <= 4'b0000;
         flags  <= 4'b0000;
      end else begin
         if (adv) begin
            s2_ev  <= ev_c;
            out_ev <= s2_ev;
         end
         if (flag_clr)
            flags <= 4'b0000;
         else if (out_valid && out_ready)
            flags <= flags | out_ev;
      end
   end
`endif

endmodule

// File: tb/tb_fmul_pipe_hs.sv
// Randomised scoreboard bench for fmul_pipe_hs (WE=4, WF=4); flag checks when FMUL_FLAGS_EN is defined.
module tb_fmul_pipe_hs;

   localparam int WE    = 4;
   localparam int WF    = 4;
   localparam int TAG_W = 8;
   localparam int W     = WE + WF + 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     X = '0;
   logic [W-1:0]     Y = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [W-1:0]     R;
   logic [TAG_W-1:0] out_tag;
`ifdef FMUL_FLAGS_EN
   logic             flag_clr = 1'b0;
   logic [3:0]       flags;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit lat_check = 1'b0;
   int rdy_mode = 0;

   typedef struct {
      logic [W-1:0]     r;
      logic [TAG_W-1:0] tag;
      logic [3:0]       fl;
      int               acc;
   } exp_t;

   exp_t sb[$];

   fmul_pipe_hs #(.WE(WE), .WF(WF), .TAG_W(TAG_W), .ID(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .R(R), .out_tag(out_tag)
`ifdef FMUL_FLAGS_EN
      , .flag_clr(flag_clr), .flags(flags)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: exact integer product of the significands, rounded to nearest-even by remainder.
   function automatic exp_t ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic [TAG_W-1:0] tag, input int acc);
      exp_t o;
      int p, msb, shift, q, rem, half, e;
      logic [1:0] xe, ye;
      logic s;
      xe = x[W-1:W-2];
      ye = y[W-1:W-2];
      s = x[WE+WF] ^ y[WE+WF];
      o.tag = tag;
      o.acc = acc;
      o.fl = 4'b0000;
      if (xe == 2'b11 || ye == 2'b11 || (xe == 2'b00 && ye == 2'b10) || (xe == 2'b10 && ye == 2'b00)) begin
         o.r = {2'b11, s, 8'h00};
         o.fl = 4'b1000;
      end else if (xe == 2'b10 || ye == 2'b10) begin
         o.r = {2'b10, s, 8'h00};
      end else if (xe == 2'b00 || ye == 2'b00) begin
         o.r = {2'b00, s, 8'h00};
      end else begin
         p = (16 + int'(x[3:0])) * (16 + int'(y[3:0]));
         msb = (p >= 512) ? 9 : 8;
         shift = msb - WF;
         q = p >> shift;
         rem = p % (1 << shift);
         half = 1 << (shift - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
         e = int'(x[7:4]) + int'(y[7:4]) - 7 + (msb - 2 * WF);
         if (q == 32) begin
            q = 16;
            e = e + 1;
         end
         if (e > 15) begin
            o.r = {2'b10, s, 8'h00};
            o.fl = 4'b0101;
         end else if (e < 0) begin
            o.r = {2'b00, s, 8'h00};
            o.fl = 4'b0011;
         end else begin
            o.r = {2'b01, s, 4'(e), 4'(q - 16)};
            o.fl = {3'b000, rem != 0};
         end
      end
      return o;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      int r;
      r = $urandom_range(0, 19);
      v = W'($urandom);
      v[W-1:W-2] = (r < 15) ? 2'b01 : (r < 17) ? 2'b00 : (r < 19) ? 2'b10 : 2'b11;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic [TAG_W-1:0] tag);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      X = x;
      Y = y;
      in_tag = tag;
      n = 0;
      #3;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (k % 4 == 0) || (k % 4 == 3);
               k++;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every output handshake, independent of the driver.
   initial begin
      bit stall_prev;
      logic [W-1:0] held_r;
      logic [TAG_W-1:0] held_tag;
      logic [3:0] exp_flags;
      logic [3:0] hs_fl;
      exp_t e;
      stall_prev = 1'b0;
      held_r = '0;
      held_tag = '0;
      exp_flags = 4'b0000;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
            exp_flags = 4'b0000;
         end else begin
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (stall_prev) begin
               checkOutput("stall_valid", {31'b0, out_valid}, 1);
               checkOutput("stall_R", R, held_r);
               checkOutput("stall_tag", out_tag, held_tag);
            end
`ifdef FMUL_FLAGS_EN
            checkOutput("flags", flags, exp_flags);
`endif
            hs_fl = 4'b0000;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checkOutput("spurious_valid", {31'b0, out_valid}, 0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("R", R, e.r);
                  checkOutput("tag", out_tag, e.tag);
                  if (lat_check) checkOutput("latency", cyc - e.acc, 3);
                  hs_fl = e.fl;
               end
            end
`ifdef FMUL_FLAGS_EN
            if (flag_clr) exp_flags = 4'b0000;
            else exp_flags = exp_flags | hs_fl;
`endif
            stall_prev = out_valid && !out_ready;
            held_r = R;
            held_tag = out_tag;
            if (in_valid && in_ready) sb.push_back(ref_mul(X, Y, in_tag, cyc));
         end
      end
   end

   initial begin
      logic [W-1:0] dx [6];
      logic [W-1:0] dy [6];
      dx = '{11'h278, 11'h278, 11'h370, 11'h2FF, 11'h200, 11'h000};
      dy = '{11'h278, 11'h271, 11'h278, 11'h2FF, 11'h200, 11'h400};

      repeat (2) @(negedge clk);
      #3;
      checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
      checkOutput("rst_R", R, 0);
      checkOutput("rst_tag", out_tag, 0);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 1);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed operands");
      lat_check = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(dx[i], dy[i], TAG_W'(8'hA0 + i));
      idle();
      waitDrain();
      lat_check = 1'b0;

      $display("[TB] random operands with random backpressure");
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(rand_op(), rand_op(), TAG_W'($urandom));
         if ($urandom_range(0, 4) == 0) idle();
      end
      idle();
      waitDrain();

      $display("[TB] back-to-back with out_ready 1,0,0,1");
      rdy_mode = 1;
      for (int i = 0; i < 10; i++) applyStimulus(rand_op(), rand_op(), TAG_W'(i + 16));
      idle();
      waitDrain();

      $display("[TB] reset with items in flight");
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) applyStimulus(11'h278, 11'h278, TAG_W'(i + 48));
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #3;
      checkOutput("post_reset_valid", {31'b0, out_valid}, 0);
      repeat (4) @(negedge clk);
      lat_check = 1'b1;
      applyStimulus(11'h278, 11'h271, 8'h5A);
      idle();
      waitDrain();
      lat_check = 1'b0;

      $display("[TB] reset during a stall");
      rdy_mode = 3;
      for (int i = 0; i < 3; i++) applyStimulus(rand_op(), rand_op(), TAG_W'(i + 64));
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #3;
      checkOutput("stall_reset_valid", {31'b0, out_valid}, 0);
      checkOutput("stall_reset_R", R, 0);
      repeat (4) @(negedge clk);
      applyStimulus(11'h370, 11'h278, 8'h77);
      idle();
      waitDrain();

`ifdef FMUL_FLAGS_EN
      $display("[TB] flag clear coinciding with overflow handshake");
      applyStimulus(11'h2FF, 11'h2FF, 8'hEE);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      #3;
      checkOutput("flags_after_clr", flags, 0);
      waitDrain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
